// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner arbiter for the shared memory/snoop bus.
// Grants one cache at a time and holds the grant until that cache drops req.
// One turnaround cycle follows every ownership. A watchdog revokes a grant
// held for TIMEOUT cycles, and the revoked cache is then skipped once.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (0 = reset)
//   req       per-cache level request, held for the whole transaction
//   gnt       one-hot registered grant; all-zero when the bus has no owner
//   gnt_id    index of the current owner; holds the last owner when gnt == 0
//   bus_busy  high while any gnt bit is set
//   timeout   one-cycle pulse when the watchdog revokes a grant
//   err_id    index of the owner that was last revoked; held until the next timeout
module bus_arbiter #(
    parameter int unsigned N_CACHE = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CACHE-1:0] req,
    output logic [N_CACHE-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               bus_busy,
    output logic               timeout,
    output logic [ID_W-1:0]    err_id
);

    localparam int unsigned IDX_W = $clog2(N_CACHE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N_CACHE-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               bus_busy_q, bus_busy_d;
    logic               timeout_q, timeout_d;
    logic [ID_W-1:0]    err_id_q, err_id_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_CACHE-1:0] mask_q, mask_d;

    logic [N_CACHE-1:0] cand;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [31:0]        scan_idx;

    // Round-robin search over unmasked requests, starting at ptr and wrapping.
    always_comb begin
        cand       = req & ~mask_q;
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int unsigned i = 0; i < N_CACHE; i++) begin
            scan_idx = 32'(ptr_q) + i;
            if (scan_idx >= N_CACHE) begin
                scan_idx = scan_idx - N_CACHE;
            end
            if (!pick_found && cand[IDX_W'(scan_idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(scan_idx);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        timeout_d = 1'b0;
        err_id_d  = err_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d               = '0;
                    gnt_d[IDX_W'(pick_id)] = 1'b1;
                    gnt_id_d            = pick_id;
                    state_d             = ST_OWN;
                    cnt_d               = '0;
                    mask_d              = '0;
                    if (32'(pick_id) == N_CACHE - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = ID_W'(32'(pick_id) + 32'd1);
                    end
                end else begin
                    // Only masked requesters (or none): lift the mask so they compete next cycle.
                    mask_d = '0;
                end
            end
            ST_OWN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A release on the watchdog cycle wins over the timeout.
                if (!req[IDX_W'(gnt_id_q)]) begin
                    gnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    gnt_d                      = '0;
                    timeout_d                  = 1'b1;
                    err_id_d                   = gnt_id_q;
                    mask_d[IDX_W'(gnt_id_q)]   = 1'b1;
                    state_d                    = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        bus_busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            bus_busy_q <= 1'b0;
            timeout_q  <= 1'b0;
            err_id_q   <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            bus_busy_q <= bus_busy_d;
            timeout_q  <= timeout_d;
            err_id_q   <= err_id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_id   = gnt_id_q;
    assign bus_busy = bus_busy_q;
    assign timeout  = timeout_q;
    assign err_id   = err_id_q;

endmodule
